// File: rtl/rcv_bit_controller_if.sv
// Received-byte handshake between the serial receive controller and its consumer.
// The controller presents a byte with ready/error status; the consumer acknowledges it.
interface rcv_bit_controller_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 data_ready;
  logic                 framing_error;
  logic                 overrun_error;
  logic                 data_read;

  modport master (
    output rx_data,
    output data_ready,
    output framing_error,
    output overrun_error,
    input  data_read
  );

  modport slave (
    input  rx_data,
    input  data_ready,
    input  framing_error,
    input  overrun_error,
    output data_read
  );

endinterface

// File: rtl/rcv_bit_controller.sv
// Serial receive controller driving an external bit-period timer and bit counter.
// Synchronizes the line, detects the start bit, samples mid-bit, shifts data in
// LSB-first, checks the stop bit and presents the byte with framing/overrun status.
module rcv_bit_controller #(
  parameter int DATA_BITS  = 8,
  parameter int TIMER_BITS = 4,
  parameter int BIT_PERIOD = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serial_in,
  input  logic                  bit_tick,
  input  logic                  bits_done,
  output logic                  timer_clear,
  output logic                  timer_enable,
  output logic [TIMER_BITS-1:0] timer_rollover_val,
  output logic                  bitcnt_clear,
  output logic                  bitcnt_enable,
  rcv_bit_controller_if.master  rx
);

  localparam logic [TIMER_BITS-1:0] HALF_VAL = TIMER_BITS'(BIT_PERIOD / 2);
  localparam logic [TIMER_BITS-1:0] FULL_VAL = TIMER_BITS'(BIT_PERIOD);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_LOAD  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_start_edge;

  logic [DATA_BITS-1:0] r_shift;
  logic                 r_stop_bit;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_data_ready;
  logic                 r_framing_error;
  logic                 r_overrun_error;

  logic                  w_timer_clear;
  logic                  w_timer_enable;
  logic [TIMER_BITS-1:0] w_rollover_val;
  logic                  w_bitcnt_clear;
  logic                  w_bitcnt_enable;

  // Two-flop synchronizer plus one history flop; all idle at line level 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Falling edge only: a line already low on entry to IDLE cannot start a frame.
  assign w_start_edge = r_prev & ~r_sync2;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and Moore counter controls (bitcnt_enable also gated by bit_tick).
  always_comb begin
    w_next          = r_state;
    w_timer_clear   = 1'b0;
    w_timer_enable  = 1'b0;
    w_rollover_val  = FULL_VAL;
    w_bitcnt_clear  = 1'b0;
    w_bitcnt_enable = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_timer_clear  = 1'b1;
        w_bitcnt_clear = 1'b1;
        w_rollover_val = HALF_VAL;
        if (w_start_edge) begin
          w_next = S_START;
        end
      end
      S_START: begin
        w_timer_enable = 1'b1;
        w_rollover_val = HALF_VAL;
        // Timer is not cleared here: after the half-period rollover it restarts at 1,
        // which places every later tick in the middle of a bit.
        if (bit_tick) begin
          w_next = r_sync2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        w_timer_enable  = 1'b1;
        w_bitcnt_enable = bit_tick;
        if (bits_done) begin
          w_next = S_STOP;
        end
      end
      S_STOP: begin
        w_timer_enable = 1'b1;
        if (bit_tick) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign timer_clear        = w_timer_clear;
  assign timer_enable       = w_timer_enable;
  assign timer_rollover_val = w_rollover_val;
  assign bitcnt_clear       = w_bitcnt_clear;
  assign bitcnt_enable      = w_bitcnt_enable;

  // Data capture: shift on mid-bit ticks in DATA, latch the stop bit in STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift    <= '0;
      r_stop_bit <= 1'b1;
    end else begin
      if (r_state == S_DATA && bit_tick) begin
        r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
      end
      if (r_state == S_STOP && bit_tick) begin
        r_stop_bit <= r_sync2;
      end
    end
  end

  // Output handshake: LOAD takes priority over a simultaneous data_read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_data       <= '0;
      r_data_ready    <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun_error <= 1'b0;
    end else if (r_state == S_LOAD) begin
      r_rx_data       <= r_shift;
      r_data_ready    <= 1'b1;
      r_framing_error <= ~r_stop_bit;
      r_overrun_error <= r_data_ready & ~rx.data_read;
    end else if (rx.data_read) begin
      r_data_ready    <= 1'b0;
      r_overrun_error <= 1'b0;
    end
  end

  assign rx.rx_data       = r_rx_data;
  assign rx.data_ready    = r_data_ready;
  assign rx.framing_error = r_framing_error;
  assign rx.overrun_error = r_overrun_error;

endmodule

// File: tb/tb_rcv_bit_controller.sv
// Bench for rcv_bit_controller: models both flex_counters, drives serial frames
// and compares the handshake outputs against a frame-level reference model.
module tb_rcv_bit_controller;

  localparam int DATA_BITS  = 8;
  localparam int TIMER_BITS = 4;
  localparam int BIT_PERIOD = 10;
  localparam int HALF       = BIT_PERIOD / 2;
  // Timer-enabled cycles per good frame: half-period start sample (count 0..HALF),
  // then one full period per data bit and one for the stop bit.
  localparam int FRAME_TE   = HALF + 1 + (DATA_BITS + 1) * BIT_PERIOD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic serial_in;
  logic bit_tick;
  logic bits_done;
  logic timer_clear;
  logic timer_enable;
  logic [TIMER_BITS-1:0] timer_rollover_val;
  logic bitcnt_clear;
  logic bitcnt_enable;

  rcv_bit_controller_if #(.DATA_BITS(DATA_BITS)) rif ();

  rcv_bit_controller #(
    .DATA_BITS (DATA_BITS),
    .TIMER_BITS(TIMER_BITS),
    .BIT_PERIOD(BIT_PERIOD)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .serial_in         (serial_in),
    .bit_tick          (bit_tick),
    .bits_done         (bits_done),
    .timer_clear       (timer_clear),
    .timer_enable      (timer_enable),
    .timer_rollover_val(timer_rollover_val),
    .bitcnt_clear      (bitcnt_clear),
    .bitcnt_enable     (bitcnt_enable),
    .rx                (rif.master)
  );

  // flex_counter models: flag while count == rollover, next count 1 after rollover.
  logic [TIMER_BITS-1:0] t_cnt;
  logic [3:0]            b_cnt;

  always_ff @(posedge clk) begin
    if (rst || timer_clear) t_cnt <= '0;
    else if (timer_enable) t_cnt <= (t_cnt == timer_rollover_val) ? TIMER_BITS'(1) : t_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || bitcnt_clear) b_cnt <= '0;
    else if (bitcnt_enable) b_cnt <= (b_cnt == 4'(DATA_BITS)) ? 4'd1 : b_cnt + 4'd1;
  end

  assign bit_tick  = (t_cnt == timer_rollover_val);
  assign bits_done = (b_cnt == 4'(DATA_BITS));

  // Activity counters sampled away from the active edge.
  int en_cnt = 0;
  int te_cnt = 0;
  always @(negedge clk) begin
    if (bitcnt_enable) en_cnt <= en_cnt + 1;
    if (timer_enable)  te_cnt <= te_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  // Reference model of the consumer-visible state.
  logic [7:0] m_rx;
  logic       m_ready;
  logic       m_fe;
  logic       m_oe;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    serial_in = b;
    repeat (BIT_PERIOD) @(posedge clk);
    #1;
  endtask

  // Start, LSB-first data, stop. rl raises data_read for the final stop-bit cycle,
  // which is the cycle the controller spends in LOAD.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic rl);
    drive_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
    serial_in = stop;
    repeat (BIT_PERIOD - 1) @(posedge clk);
    #1;
    if (rl) rif.data_read = 1'b1;
    @(posedge clk);
    #1;
    rif.data_read = 1'b0;
    serial_in = 1'b1;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, ".rx_data"},       32'(rif.rx_data),       32'(m_rx));
    check({pfx, ".data_ready"},    32'(rif.data_ready),    32'(m_ready));
    check({pfx, ".framing_error"}, 32'(rif.framing_error), 32'(m_fe));
    check({pfx, ".overrun_error"}, 32'(rif.overrun_error), 32'(m_oe));
  endtask

  task automatic frame(input logic [7:0] d, input logic stop, input logic rl);
    int en0;
    int te0;
    en0 = en_cnt;
    te0 = te_cnt;
    send_frame(d, stop, rl);
    m_oe    = m_ready && !rl;
    m_ready = 1'b1;
    m_rx    = d;
    m_fe    = !stop;
    idle(2);
    check_outputs("frame");
    check("frame.bitcnt_enables", 32'(en_cnt - en0), 32'(DATA_BITS));
    check("frame.timer_enables",  32'(te_cnt - te0), 32'(FRAME_TE));
  endtask

  task automatic do_read();
    rif.data_read = 1'b1;
    @(posedge clk);
    #1;
    rif.data_read = 1'b0;
    m_ready = 1'b0;
    m_oe    = 1'b0;
    check("read.data_ready",    32'(rif.data_ready),    32'(0));
    check("read.overrun_error", 32'(rif.overrun_error), 32'(0));
  endtask

  task automatic check_reset(input string pfx);
    m_rx = '0; m_ready = 1'b0; m_fe = 1'b0; m_oe = 1'b0;
    check_outputs(pfx);
    check({pfx, ".timer_clear"},   32'(timer_clear),        32'(1));
    check({pfx, ".bitcnt_clear"},  32'(bitcnt_clear),       32'(1));
    check({pfx, ".timer_enable"},  32'(timer_enable),       32'(0));
    check({pfx, ".bitcnt_enable"}, 32'(bitcnt_enable),      32'(0));
    check({pfx, ".rollover_val"},  32'(timer_rollover_val), 32'(HALF));
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    logic       rl;
    int         en0;
    int         te0;

    rst = 1'b1;
    serial_in = 1'b1;
    rif.data_read = 1'b0;
    idle(3);
    check_reset("reset");
    rst = 1'b0;
    idle(4);

    // Good frame, then acknowledge.
    frame(8'hA5, 1'b1, 1'b0);
    do_read();

    // Bad stop bit, then a good frame clears framing_error.
    frame(8'h3C, 1'b0, 1'b0);
    do_read();
    frame(8'h00, 1'b1, 1'b0);
    do_read();

    // Two frames without a read: overrun.
    frame(8'h11, 1'b1, 1'b0);
    frame(8'h22, 1'b1, 1'b0);
    do_read();

    // Short low glitch: START is entered, rejected at the mid-bit sample.
    en0 = en_cnt;
    te0 = te_cnt;
    serial_in = 1'b0;
    idle(3);
    serial_in = 1'b1;
    idle(3 * BIT_PERIOD);
    check("glitch.timer_clear",    32'(timer_clear),    32'(1));
    check("glitch.bitcnt_enables", 32'(en_cnt - en0),   32'(0));
    check("glitch.timer_enables",  32'(te_cnt - te0),   32'(HALF + 1));
    check_outputs("glitch");

    // Leave a nonzero byte pending, then reset in the middle of a frame.
    frame(8'h9C, 1'b0, 1'b0);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset("midrst");
    idle(6 * BIT_PERIOD);
    check_reset("postrst");
    frame(8'h5A, 1'b1, 1'b0);
    do_read();

    // data_read coinciding with LOAD: load wins, no overrun.
    frame(8'h66, 1'b1, 1'b0);
    frame(8'h77, 1'b1, 1'b1);

    // Randomized frames against the model.
    for (int n = 0; n < 10; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(3) != 0);
      rl   = ($urandom_range(3) == 0);
      frame(d, stop, rl);
      if ($urandom_range(1) == 1) do_read();
      idle($urandom_range(10));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rcv_bit_controller.md
# rcv_bit_controller

Serial receive controller that sits directly downstream of two external `flex_counter` instances: a bit-period timer and a bit counter. It consumes their rollover flags and drives their `clear`, `count_enable` and rollover value. It synchronizes the serial line, detects the start bit, samples mid-bit and shifts the data in LSB-first. It checks the stop bit and presents each received byte with a ready/read handshake, plus framing and overrun status.

## Interface
Parameters:
- DATA_BITS, 8, data bits per frame; the bit counter's rollover value is tied to this externally.
- TIMER_BITS, 4, width of the timer rollover value output.
- BIT_PERIOD, 10, clocks per serial bit; must be ≥ 4 and < 2^TIMER_BITS.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  system clock, all state on posedge.
- rst  input  1  synchronous active-high reset.
- serial_in  input  1  asynchronous serial line; idles high.
- bit_tick  input  1  rollover_flag from the bit-period timer.
- bits_done  input  1  rollover_flag from the bit counter.
- data_read  input  1  consumer acknowledges rx_data.
- timer_clear  output  1  clear for the timer; clear_val is 0 externally.
- timer_enable  output  1  count_enable for the timer.
- timer_rollover_val  output  TIMER_BITS  rollover_val for the timer.
- bitcnt_clear  output  1  clear for the bit counter.
- bitcnt_enable  output  1  count_enable for the bit counter.
- rx_data  output  DATA_BITS  last received byte.
- data_ready  output  1  rx_data valid and unread.
- framing_error  output  1  stop bit of last frame was 0.
- overrun_error  output  1  a frame was loaded over unread data.

## Operation
- Input path: two-flop synchronizer on serial_in, then a third flop for edge history. All three reset to 1.
- A start edge is sync=0 with prev=1.
- FSM states: IDLE, START, DATA, STOP, LOAD. Reset state is IDLE.
- Moore decode of counter controls:
  - IDLE: timer_clear=1, bitcnt_clear=1, enables 0.
  - START, DATA, STOP: timer_enable=1.
  - LOAD: all 0.
- timer_rollover_val is BIT_PERIOD/2 (integer division) in IDLE and START. In all other states it is BIT_PERIOD.
- bitcnt_enable is combinational: 1 only when state==DATA and bit_tick==1.
- IDLE → START on a start edge.
- START, on bit_tick (mid start bit):
  - If sync==0, go to DATA.
  - If sync==1 (glitch), return to IDLE and produce no output.
  - The timer is not cleared; it continues from 1 to BIT_PERIOD.
- DATA:
  - On bit_tick, shift right: shift_reg <= {sync, shift_reg[DATA_BITS-1:1]}, so the first bit lands in the LSB at the end.
  - When bits_done==1, go to STOP. This is the cycle after the DATA_BITS-th tick.
- STOP: on bit_tick, latch stop_bit=sync and go to LOAD.
- LOAD lasts one cycle, then IDLE. On that edge:
  - rx_data<=shift_reg; data_ready<=1; framing_error<=~stop_bit.
  - overrun_error<=1 if data_ready==1 and data_read==0.
- data_read clears data_ready and overrun_error on the next edge when no LOAD is in progress.
- If data_read and LOAD coincide, LOAD wins: data_ready stays 1 and no overrun is flagged.
- framing_error holds until the next LOAD.
- Reset values: rx_data 0, data_ready 0, framing_error 0, overrun_error 0, shift_reg 0. Counter controls take their IDLE values.
- rst mid-frame: next edge is IDLE and the partial frame is discarded. rx_data is zeroed.
- A start edge seen in LOAD is ignored. A line low in IDLE without a falling edge does not start a frame.

## Timing
- serial_in fall → START: 3 clocks (2 sync + edge register).
- Start-bit sample: BIT_PERIOD/2 clocks after entering START.
- Data samples follow every BIT_PERIOD clocks.
- Stop sample → data_ready high: 2 edges (STOP→LOAD, LOAD registers outputs).
- Frame-to-frame: the FSM is back in IDLE about BIT_PERIOD/2 clocks into the stop bit, ready for back-to-back frames.

## Test plan
The bench models both counters per flex_counter semantics: flag high while count == rollover value, next count 1 after rollover. BIT_PERIOD=10, DATA_BITS=8.
- Frame 0xA5 with stop=1 → rx_data=0xA5, data_ready=1, framing_error=0. data_read for one cycle → data_ready=0 on the next edge.
- Frame 0x3C with stop=0 → rx_data=0x3C, framing_error=1. A following good frame 0x00 → framing_error=0.
- Two frames 0x11 then 0x22 with no data_read → rx_data=0x22, overrun_error=1. data_read → overrun_error=0, data_ready=0.
- 3-clock low glitch on an idle line → FSM returns to IDLE after the START sample, data_ready stays 0, bitcnt_enable never asserts.
- rst pulsed for 1 cycle after the 4th data bit of frame 0xFF → all outputs at reset values. The next frame 0x5A is received correctly.
- data_read asserted in the same cycle as LOAD of 0x77 while 0x66 is unread → data_ready=1, rx_data=0x77, overrun_error=0.
